multu_seq: RTL

Sequential 32×32 unsigned shift-add multiplier that produces the 64-bit product consumed by the HI/LO register stage. It accepts an operand pair plus the decoded opcode (MULTU or MADDU), iterates one partial product per clock, and presents the full product with a one-cycle done pulse. The opcode travels with the result, so the HI/LO stage either loads the product (MULTU) or accumulates it (MADDU).

---
 rtl/mul_pkg.sv | 20 ++
 rtl/multu_seq_if.sv | 28 ++
 rtl/multu_seq.sv | 95 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier definitions: opcode tags, FSM states and default width.
// The opcode constants are also used by the HI/LO register stage.
package mul_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MADDU = 6'd1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic op_ok(input logic [5:0] op);
    return (op == OP_MULTU) || (op == OP_MADDU);
  endfunction

endpackage

// File: rtl/multu_seq_if.sv
// Request/result bundle between the issue logic and the sequential
// multiplier; master issues operands, slave returns the tagged product.
interface multu_seq_if
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic               start;
  logic [5:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [5:0]         mul_op;
  logic [2*WIDTH-1:0] mul_ans;

  modport master (
    output start, op, a, b,
    input  busy, done, mul_op, mul_ans
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, mul_op, mul_ans
  );

endinterface

// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier, one partial product per clock.
// The opcode tag rides along so HI/LO can load or accumulate the product.
module multu_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  multu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    ans_q, ans_d;
  logic [5:0]       op_q, op_d;

  logic             idle_or_done;
  logic             accept;
  logic             last;
  logic [PW-1:0]    acc_sum;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign accept  = bus.start && op_ok(bus.op) && idle_or_done;
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    ans_d    = ans_q;
    op_d     = op_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = RUN;
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          op_d     = bus.op;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Final partial product lands straight in the result register.
        if (last) begin
          state_d = DONE;
          ans_d   = acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      ans_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      ans_q    <= ans_d;
      op_q     <= op_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.mul_op  = op_q;
  assign bus.mul_ans = ans_q;

endmodule
